// File: rtl/decode_queue_pkg.sv
// Shared opcode constants and the decoded control bundle for decode_queue.
package decode_queue_pkg;

    localparam logic [5:0] F6_RTYPE = 6'b000000;
    localparam logic [5:0] F6_J     = 6'b000010;
    localparam logic [5:0] F6_JAL   = 6'b000011;
    localparam logic [5:0] F6_BEQ   = 6'b000100;
    localparam logic [5:0] F6_BNE   = 6'b000101;
    localparam logic [5:0] F6_ADDI  = 6'b001000;
    localparam logic [5:0] F6_ADDIU = 6'b001001;
    localparam logic [5:0] F6_ANDI  = 6'b001100;
    localparam logic [5:0] F6_ORI   = 6'b001101;
    localparam logic [5:0] F6_LUI   = 6'b001111;
    localparam logic [5:0] F6_LW    = 6'b100011;
    localparam logic [5:0] F6_SW    = 6'b101011;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       link;
        logic [5:0] alu_op;
    } dec_ctrl_t;

endpackage

// File: rtl/decode_queue_fifo.sv
// Instruction queue for decode_queue: DEPTH entries, pointers with a wrap bit.
module decode_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

endmodule

// File: rtl/decode_queue.sv
// MIPS decode stage: instruction queue, decoder, load-use interlock, output register.
// Optional DECODE_PERF_EN adds saturating perf_issued/perf_stall counters.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int PERF_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc_plus_4,
    input  logic [31:0]     in_instr,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc_plus_4,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_dst,
    output logic [XLEN-1:0] out_imm32,
    output logic [25:0]     out_offset,
    output dec_ctrl_t       out_ctrl,
    output logic            out_illegal
`ifdef DECODE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_issued,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] pc_plus_4;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      dst;
        logic [XLEN-1:0] imm32;
        logic [25:0]     offset;
        dec_ctrl_t       ctrl;
        logic            illegal;
    } out_reg_t;

    logic [XLEN+31:0] head_word;
    logic [XLEN-1:0]  head_pc;
    logic [31:0]      head_instr;
    logic             full;
    logic             empty;
    logic             push;
    logic             issue;
    logic             hazard;
    logic             rt_src;
    logic [5:0]       op;
    logic [15:0]      imm16;
    out_reg_t         out_d;
    out_reg_t         out_q;

    assign in_ready = !full;
    assign push     = in_valid && !full;

    decode_fifo #(
        .WIDTH(XLEN + 32),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .push (push),
        .pop  (issue),
        .wdata({in_pc_plus_4, in_instr}),
        .rdata(head_word),
        .full (full),
        .empty(empty)
    );

    assign head_pc    = head_word[XLEN+31:32];
    assign head_instr = head_word[31:0];
    assign op         = head_instr[31:26];
    assign imm16      = head_instr[15:0];
    assign rf_raddr1  = head_instr[25:21];
    assign rf_raddr2  = head_instr[20:16];

    always_comb begin
        out_d           = '0;
        rt_src          = 1'b0;
        out_d.pc_plus_4 = head_pc;
        out_d.rd1       = rf_rdata1;
        out_d.rd2       = rf_rdata2;
        out_d.rs        = head_instr[25:21];
        out_d.rt        = head_instr[20:16];
        out_d.dst       = head_instr[20:16];
        out_d.imm32     = XLEN'($signed(imm16));
        out_d.offset    = head_instr[25:0];
        out_d.ctrl.alu_op = op;
        case (op)
            F6_RTYPE: begin
                out_d.ctrl.reg_write = (head_instr != '0);
                out_d.ctrl.reg_dst   = 1'b1;
                out_d.ctrl.alu_op    = head_instr[5:0];
                out_d.dst            = head_instr[15:11];
                rt_src               = 1'b1;
            end
            F6_ADDI, F6_ADDIU: begin
                out_d.ctrl.alu_src   = 1'b1;
                out_d.ctrl.reg_write = 1'b1;
            end
            F6_ANDI, F6_ORI: begin
                out_d.ctrl.alu_src   = 1'b1;
                out_d.ctrl.reg_write = 1'b1;
                out_d.imm32          = XLEN'(imm16);
            end
            F6_LUI: begin
                out_d.ctrl.alu_src   = 1'b1;
                out_d.ctrl.reg_write = 1'b1;
                out_d.imm32          = XLEN'({imm16, 16'h0000});
            end
            F6_LW: begin
                out_d.ctrl.mem_to_reg = 1'b1;
                out_d.ctrl.reg_write  = 1'b1;
            end
            F6_SW: begin
                out_d.ctrl.mem_write = 1'b1;
                rt_src               = 1'b1;
            end
            F6_BEQ: begin
                out_d.ctrl.branch = 1'b1;
                rt_src            = 1'b1;
            end
            F6_BNE: begin
                out_d.ctrl.branch_ne = 1'b1;
                rt_src               = 1'b1;
            end
            F6_J: begin
                out_d.ctrl.jump = 1'b1;
            end
            F6_JAL: begin
                out_d.ctrl.jump      = 1'b1;
                out_d.ctrl.link      = 1'b1;
                out_d.ctrl.reg_write = 1'b1;
                out_d.dst            = 5'd31;
            end
            default: begin
                out_d.ctrl    = '0;
                out_d.illegal = 1'b1;
            end
        endcase
    end

    // A load waiting in the output register blocks a dependent head; the cycle it
    // drains leaves out_valid low, which is the single bubble.
    assign hazard = out_valid && out_q.ctrl.mem_to_reg && (out_q.dst != '0) &&
                    ((out_q.dst == out_d.rs) || (rt_src && (out_q.dst == out_d.rt)));
    assign issue  = !empty && !hazard && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_q     <= out_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_pc_plus_4 = out_q.pc_plus_4;
    assign out_rd1       = out_q.rd1;
    assign out_rd2       = out_q.rd2;
    assign out_rs        = out_q.rs;
    assign out_rt        = out_q.rt;
    assign out_dst       = out_q.dst;
    assign out_imm32     = out_q.imm32;
    assign out_offset    = out_q.offset;
    assign out_ctrl      = out_q.ctrl;
    assign out_illegal   = out_q.illegal;

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (flush) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue && (perf_issued != '1)) perf_issued <= perf_issued + 1'b1;
            if (!empty && hazard && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
        end
    end
`else
    logic [31:0] perf_w_unused;
    assign perf_w_unused = PERF_W;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed cases, then randomized traffic.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc_plus_4;
    logic [31:0]     in_instr;
    logic [4:0]      rf_raddr1, rf_raddr2;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc_plus_4, out_rd1, out_rd2, out_imm32;
    logic [4:0]      out_rs, out_rt, out_dst;
    logic [25:0]     out_offset;
    dec_ctrl_t       out_ctrl;
    logic            out_illegal;
`ifdef DECODE_PERF_EN
    logic [31:0]     perf_issued, perf_stall;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [25:0] off;
        dec_ctrl_t   ctrl;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc_cnt = 0;
    logic [31:0] pc_ctr = 32'h0000_1004;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_plus_4(in_pc_plus_4), .in_instr(in_instr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc_plus_4(out_pc_plus_4), .out_rd1(out_rd1), .out_rd2(out_rd2),
        .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst),
        .out_imm32(out_imm32), .out_offset(out_offset),
        .out_ctrl(out_ctrl), .out_illegal(out_illegal)
`ifdef DECODE_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return {a, a, a, a, a, a, 2'b01};
    endfunction

    assign rf_rdata1 = rf_val(rf_raddr1);
    assign rf_rdata2 = rf_val(rf_raddr2);

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] func);
        return {6'b000000, rs, rt, rd, 5'b00000, func};
    endfunction

    // Reference decode straight from the opcode table.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] instr);
        exp_t        e;
        logic [5:0]  op;
        logic [15:0] imm;
        op    = instr[31:26];
        imm   = instr[15:0];
        e     = '0;
        e.pc  = pc;
        e.rs  = instr[25:21];
        e.rt  = instr[20:16];
        e.rd1 = rf_val(e.rs);
        e.rd2 = rf_val(e.rt);
        e.off = instr[25:0];
        e.imm = {{16{imm[15]}}, imm};
        e.dst = e.rt;
        if (op == F6_RTYPE) begin
            e.ctrl.reg_write = (instr != 32'h0);
            e.ctrl.reg_dst   = 1'b1;
            e.ctrl.alu_op    = instr[5:0];
            e.dst            = instr[15:11];
        end else if (op inside {F6_ADDI, F6_ADDIU, F6_ANDI, F6_ORI, F6_LUI, F6_LW,
                                F6_SW, F6_BEQ, F6_BNE, F6_J, F6_JAL}) begin
            e.ctrl.alu_op     = op;
            e.ctrl.alu_src    = op inside {F6_ADDI, F6_ADDIU, F6_ANDI, F6_ORI, F6_LUI};
            e.ctrl.reg_write  = op inside {F6_ADDI, F6_ADDIU, F6_ANDI, F6_ORI, F6_LUI, F6_LW, F6_JAL};
            e.ctrl.mem_to_reg = (op == F6_LW);
            e.ctrl.mem_write  = (op == F6_SW);
            e.ctrl.branch     = (op == F6_BEQ);
            e.ctrl.branch_ne  = (op == F6_BNE);
            e.ctrl.jump       = op inside {F6_J, F6_JAL};
            e.ctrl.link       = (op == F6_JAL);
            if (op inside {F6_ANDI, F6_ORI}) e.imm = {16'h0000, imm};
            if (op == F6_LUI) e.imm = {imm, 16'h0000};
            if (op == F6_JAL) e.dst = 5'd31;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic bit depends(input exp_t p, input exp_t c);
        bit rt_src;
        rt_src = c.ctrl.reg_dst || c.ctrl.mem_write || c.ctrl.branch || c.ctrl.branch_ne;
        return p.ctrl.mem_to_reg && (p.dst != 5'd0) &&
               ((p.dst == c.rs) || (rt_src && (p.dst == c.rt)));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  op;
        logic [31:0] w;
        case ($urandom_range(0, 12))
            0:  op = F6_RTYPE;
            1:  op = F6_ADDI;
            2:  op = F6_ADDIU;
            3:  op = F6_ANDI;
            4:  op = F6_ORI;
            5:  op = F6_LUI;
            6:  op = F6_LW;
            7:  op = F6_LW;
            8:  op = F6_SW;
            9:  op = F6_BEQ;
            10: op = F6_BNE;
            11: op = ($urandom_range(0, 1) == 0) ? F6_J : F6_JAL;
            default: op = 6'b111111;
        endcase
        w = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        if ($urandom_range(0, 19) == 0) w = 32'h0;
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected responses enter the scoreboard when fetch hands an instruction over.
    always @(negedge clk) begin
        if (rst_n && !flush && in_valid && in_ready)
            exp_q.push_back(model(in_pc_plus_4, in_instr));
    end

    exp_t        last_e;
    bit          last_ok = 1'b0;
    int unsigned last_cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (!rst_n) begin
            exp_q.delete();
            last_ok = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                got = {out_pc_plus_4, out_rd1, out_rd2, out_rs, out_rt, out_dst,
                       out_imm32, out_offset, out_ctrl, out_illegal};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected actual=%h required=none", got);
                    e = got;
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL sb_entry actual=%h required=%h", got, e);
                    end
                    if (last_ok && depends(last_e, e)) begin
                        checks++;
                        if (cyc_cnt - last_cyc < 2) begin
                            errors++;
                            $display("FAIL load_use_gap actual=%0d required>=2", cyc_cnt - last_cyc);
                        end
                    end
                end
                last_e   = e;
                last_ok  = 1'b1;
                last_cyc = cyc_cnt;
            end
            if (flush) begin
                exp_q.delete();
                last_ok = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr);
        int n;
        in_valid     = 1'b1;
        in_instr     = instr;
        in_pc_plus_4 = pc_ctr;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", 64'(in_ready), 64'(1));
        cyc();
        in_valid = 1'b0;
        pc_ctr   = pc_ctr + 32'd4;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 64'(out_valid), 64'(1));
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_pc_plus_4 = '0;
        in_instr     = '0;
        out_ready    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(1));
        check("rst_pc", 64'(out_pc_plus_4), 64'(0));
        check("rst_ctrl", 64'(out_ctrl), 64'(0));
        check("rst_dst_imm", 64'({out_dst, out_imm32, out_illegal}), 64'(0));
        cyc();
        rst_n = 1'b1;

        // reset in the middle of a stream
        push_one(itype(F6_ADDI, 5'd1, 5'd2, 16'h0011));
        push_one(itype(F6_ORI, 5'd3, 5'd4, 16'h0022));
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_ready", 64'(in_ready), 64'(1));
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // immediates and minimum latency
        push_one(itype(F6_ORI, 5'd0, 5'd2, 16'h8001));
        @(negedge clk);
        check("lat_early", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("lat_valid", 64'(out_valid), 64'(1));
        check("ori_imm", 64'(out_imm32), 64'h0000_8001);
        cyc();
        push_one(itype(F6_ADDI, 5'd0, 5'd2, 16'h8001));
        wait_out("addi");
        check("addi_imm", 64'(out_imm32), 64'hFFFF_8001);
        cyc();
        push_one(itype(F6_LUI, 5'd0, 5'd3, 16'h1234));
        wait_out("lui");
        check("lui_imm", 64'(out_imm32), 64'h1234_0000);
        cyc();

        // load-use: exactly one bubble
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        push_one(itype(F6_LW, 5'd1, 5'd5, 16'h0000));
        push_one(rtype(5'd5, 5'd7, 5'd6, 6'h20));
        @(negedge clk);
        check("lw_out", 64'({out_valid, out_ctrl.mem_to_reg}), 64'(3));
        @(negedge clk);
        check("lu_bubble", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("add_after", 64'({out_valid, out_rs}), 64'({1'b1, 5'd5}));
`ifdef DECODE_PERF_EN
        check("perf_stall", 64'(perf_stall), 64'(1));
        check("perf_issued", 64'(perf_issued), 64'(2));
`endif
        cyc();
        drain();

        // backpressure: queue plus output register absorb DEPTH+1
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid     = 1'b1;
            in_instr     = itype(F6_ADDIU, 5'd0, 5'(i + 1), 16'(i * 3));
            in_pc_plus_4 = pc_ctr;
            @(negedge clk);
            if (in_ready) begin
                acc++;
                pc_ctr = pc_ctr + 32'd4;
            end
            cyc();
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'(DEPTH + 1));
        @(negedge clk);
        check("bp_ready", 64'(in_ready), 64'(0));
        cyc();
        drain();

        // JAL
        push_one({F6_JAL, 26'h0000100});
        wait_out("jal");
        check("jal_dst", 64'(out_dst), 64'(31));
        check("jal_ctrl", 64'({out_ctrl.link, out_ctrl.reg_write, out_ctrl.jump}), 64'(7));
        check("jal_offset", 64'(out_offset), 64'h100);
        cyc();

        // flush with full queue and a simultaneous offer
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push_one(itype(F6_ADDIU, 5'd0, 5'd9, 16'(i)));
        in_valid = 1'b1;
        in_instr = itype(F6_ORI, 5'd0, 5'd10, 16'hBEEF);
        flush    = 1'b1;
        @(negedge clk);
        check("fl_pre_ready", 64'(in_ready), 64'(0));
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_valid", 64'(out_valid), 64'(0));
        check("fl_ready", 64'(in_ready), 64'(1));
        check("fl_pc", 64'(out_pc_plus_4), 64'(0));
`ifdef DECODE_PERF_EN
        check("fl_perf", 64'(perf_issued), 64'(0));
`endif
        cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fl_discard", 64'(out_valid), 64'(0));
            cyc();
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            flush        = ($urandom_range(0, 149) == 0);
            in_valid     = ($urandom_range(0, 9) < 7);
            in_instr     = rand_instr();
            in_pc_plus_4 = $urandom;
            out_ready    = ($urandom_range(0, 9) < 7);
            cyc();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Next-generation MIPS decode stage.
- Decouples fetch from execute through a parametrised instruction queue and a valid/ready handshake on both sides.
- Decodes an extended opcode set: ANDI/ORI zero-extend, LUI, BNE, JAL.
- Generates load-use interlock bubbles internally, so the stage needs no external stall input.

Parameters:
- XLEN, 32, datapath/PC width
- DEPTH, 4, instruction queue entries (power of two, ≥2)
- PERF_W, 32, performance counter width (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard queue and output register
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue not full
- in_pc_plus_4  in  XLEN  PC+4 of the offered instruction
- in_instr  in  32  instruction word
- rf_raddr1, rf_raddr2  out  5 each  rs/rt of queue head
- rf_rdata1, rf_rdata2  in  XLEN each  combinational register-file read data
- out_valid  out  1  output register holds a decoded instruction
- out_ready  in  1  execute accepts it
- out_pc_plus_4, out_rd1, out_rd2  out  XLEN each  registered fields
- out_rs, out_rt, out_dst  out  5 each  out_dst is the resolved write register
- out_imm32  out  XLEN  extended immediate
- out_offset  out  26  jump target field
- out_ctrl  out  dec_ctrl_t  control bundle
- out_illegal  out  1  unknown opcode

Behaviour:
- Clocking: single clock domain on clk; rst_n asynchronous, active-low.
- Reset (and flush): queue empty, out_valid=0, all out_* fields 0.
- Push: on in_valid && in_ready; in_ready = !full; no full-bypass, so a push is refused when full even if a pop happens in the same cycle.
- Output register load ("issue") when all hold:
  - queue not empty
  - no hazard
  - (!out_valid || out_ready)
- Issue pops the head. If out_valid && out_ready and nothing issues, out_valid goes to 0 next edge.
- Minimum latency: push at edge N, out_valid at edge N+1. Throughput is 1/cycle absent hazards.
- Hazard condition, all of:
  - out_valid
  - out_ctrl.mem_to_reg
  - out_dst != 0
  - out_dst equals head rs, or head rt where rt is a source (R-type, SW, BEQ, BNE)
- While the hazard holds the head stays queued. Once the load is consumed, exactly one bubble (out_valid=0) is inserted.
- Flush:
  - Clears the queue pointers and out_valid at the next edge.
  - Dominates a simultaneous push and issue.
  - in_ready stays combinational from the pre-flush count.
- Decode table:
  - R-type 000000: reg_write, reg_dst, alu_op=func
  - ADDI 001000, ADDIU 001001: sign-extend, alu_src, reg_write
  - ANDI 001100, ORI 001101: zero-extend, alu_src, reg_write
  - LUI 001111: imm32={imm16,16'b0}, alu_src, reg_write
  - LW 100011: sign-extend, mem_to_reg, reg_write
  - SW 101011: sign-extend, mem_write
  - BEQ 000100: branch, sign-extend
  - BNE 000101: branch_ne, sign-extend
  - J 000010: jump
  - JAL 000011: jump, link, reg_write, out_dst=31
  - For all non-R-type opcodes, alu_op=op.
- Special cases:
  - out_dst = rd for R-type, 31 for JAL, else rt.
  - instr==0: reg_write=0.
  - Unknown opcode: all ctrl bits 0, out_illegal=1; it still issues normally.
- Wrap-around: pointers carry one extra bit; full when the MSBs differ and the low bits are equal.

Optional Feature:
- DECODE_PERF_EN defined adds outputs perf_issued and perf_stall (PERF_W each).
  - perf_issued: +1 per issue.
  - perf_stall: +1 per cycle with queue non-empty and hazard true.
  - Counters saturate at all-ones and clear on reset and on flush.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package common: F6_* opcode constants, including the new F6_ADDIU, F6_ANDI, F6_ORI, F6_LUI, F6_BNE, F6_JAL.
- Package pipes: dec_ctrl_t packed struct {reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, branch_ne, jump, link, alu_op[5:0]}.
- Sub-module decode_fifo: parametrised DEPTH×(XLEN+32) queue with push/pop/flush, full/empty.

Test Plan:
- Reset mid-stream: rst_n low after 2 pushes → out_valid=0, in_ready=1, next push decodes cleanly.
- ORI $2,$0,0x8001 → imm32=0x00008001. ADDI $2,$0,0x8001 → 0xFFFF8001. LUI $3,0x1234 → 0x12340000.
- LW $5,0($1) then ADD $6,$5,$7 with out_ready=1 → exactly one out_valid=0 cycle between them; perf_stall=1.
- out_ready=0 for 10 cycles with continuous pushes → in_ready drops after DEPTH+1 instructions accepted, and none are lost or reordered.
- JAL 0x0000100 → out_dst=31, link=1, reg_write=1, out_offset=0x0000100.
- Flush with queue full and simultaneous in_valid → next cycle queue empty, out_valid=0, and the pushed word is discarded.
